// File: rtl/rw_command_arbiter.sv
// rw_command_arbiter: merges frontend reads with buffered writes into one registered command stream, with turnaround bubbles.
// Optional RW_ARB_OPPORTUNISTIC_WRITE_EN drains writes after IDLE_WRITE_DELAY read-idle cycles.
module rw_command_arbiter #(
  parameter int DATA_WIDTH       = 32,
  parameter int TURNAROUND       = 2,
  parameter int IDLE_WRITE_DELAY = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_rd_valid,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  output logic                  o_rd_ready,
  input  logic [DATA_WIDTH-1:0] i_wfifo_data,
  input  logic                  i_wfifo_empty,
  input  logic                  i_write_flush,
  output logic                  o_wfifo_rd_en,
  output logic                  o_cmd_valid,
  output logic [DATA_WIDTH-1:0] o_cmd_data,
  output logic                  o_cmd_is_write,
  input  logic                  i_cmd_ready,
  output logic [1:0]            o_state
);
  typedef enum logic [1:0] {READ = 2'd0, TURN_W = 2'd1, WRITE = 2'd2, TURN_R = 2'd3} state_t;
  localparam int TW = TURNAROUND > 0 ? $clog2(TURNAROUND + 1) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TURNAROUND);
  if (IDLE_WRITE_DELAY < 1 || TURNAROUND < 0) begin : g_param_check
    $error("rw_command_arbiter: IDLE_WRITE_DELAY must be >= 1 and TURNAROUND >= 0");
  end
  state_t state_q, state_d;
  logic [TW-1:0] turn_q, turn_d;
  logic cmd_valid_q, cmd_valid_d, cmd_is_write_q, cmd_is_write_d;
  logic [DATA_WIDTH-1:0] cmd_data_q, cmd_data_d;
  logic out_free, switch_w, go_w, exit_w, turn_done, rd_acc, pop;
  assign out_free      = !cmd_valid_q || i_cmd_ready;
  assign switch_w      = i_write_flush && !i_wfifo_empty;
  assign turn_done     = (TURNAROUND == 0) || (turn_q == TW'(TURNAROUND - 1));
  assign o_rd_ready    = !i_rst && state_q == READ && out_free && !switch_w;
  assign o_wfifo_rd_en = !i_rst && state_q == WRITE && out_free && !i_wfifo_empty;
  assign rd_acc        = o_rd_ready && i_rd_valid && !go_w;
  assign pop           = o_wfifo_rd_en;
`ifdef RW_ARB_OPPORTUNISTIC_WRITE_EN
  localparam int IW = $clog2(IDLE_WRITE_DELAY + 1);
  localparam logic [IW-1:0] IMAX = IW'(IDLE_WRITE_DELAY);
  logic [IW-1:0] idle_q, idle_d;
  logic opp_q, opp_d, go_opp;
  // Opportunistic drain only fires on a read-idle cycle, so it never races a read accept.
  assign go_opp = state_q == READ && idle_q == IMAX && !i_wfifo_empty && !i_rd_valid;
  assign go_w   = switch_w || go_opp;
  assign exit_w = i_wfifo_empty || ((opp_q && !i_write_flush) ? i_rd_valid : !i_write_flush);
  always_comb begin
    idle_d = (state_d != state_q || i_rd_valid) ? '0 : (idle_q == IMAX ? idle_q : idle_q + IW'(1));
    opp_d  = (go_opp && !switch_w) ? 1'b1 : ((i_write_flush || state_d == READ) ? 1'b0 : opp_q);
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      idle_q <= '0;
      opp_q  <= 1'b0;
    end else begin
      idle_q <= idle_d;
      opp_q  <= opp_d;
    end
  end
`else
  assign go_w   = switch_w;
  assign exit_w = !i_write_flush || i_wfifo_empty;
`endif
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      READ:   if (go_w) state_d = (TURNAROUND == 0) ? WRITE : TURN_W;
      TURN_W: if (turn_done) state_d = WRITE;
      WRITE:  if (exit_w) state_d = (TURNAROUND == 0) ? READ : TURN_R;
      TURN_R: if (turn_done) state_d = READ;
    endcase
  end
  always_comb begin
    turn_d         = (state_d != state_q) ? '0 : (turn_q == TMAX ? turn_q : turn_q + TW'(1));
    cmd_valid_d    = out_free ? (rd_acc || pop) : cmd_valid_q;
    cmd_is_write_d = out_free ? pop : cmd_is_write_q;
    cmd_data_d     = !out_free ? cmd_data_q : (pop ? i_wfifo_data : (rd_acc ? i_rd_data : cmd_data_q));
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q        <= READ;
      turn_q         <= '0;
      cmd_valid_q    <= 1'b0;
      cmd_is_write_q <= 1'b0;
      cmd_data_q     <= '0;
    end else begin
      state_q        <= state_d;
      turn_q         <= turn_d;
      cmd_valid_q    <= cmd_valid_d;
      cmd_is_write_q <= cmd_is_write_d;
      cmd_data_q     <= cmd_data_d;
    end
  end
  assign o_cmd_valid    = cmd_valid_q;
  assign o_cmd_data     = cmd_data_q;
  assign o_cmd_is_write = cmd_is_write_q;
  assign o_state        = state_q;
endmodule

// File: tb/tb_rw_command_arbiter.sv
// tb_rw_command_arbiter: directed checks of read/write arbitration, turnaround, backpressure and reset.
module tb_rw_command_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic rd_valid = 1'b0, flush = 1'b0, cmd_ready = 1'b1;
  logic [31:0] rd_data = '0;
  logic rd_ready, rd_en, cmd_valid, cmd_is_write, wempty;
  logic [31:0] wdata, cmd_data;
  logic [1:0] state;
  logic z_flush = 1'b0, z_empty = 1'b1;
  logic [31:0] z_wdata = '0;
  logic z_rd_ready, z_rd_en, z_valid, z_wr;
  logic [31:0] z_cmd;
  logic [1:0] z_state;
  logic [31:0] mem [16];
  logic [3:0] rp = '0, wp = '0;
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  assign wdata  = mem[rp];
  assign wempty = rp == wp;
  always @(posedge clk) begin
    if (rst) rp <= wp;
    else if (rd_en) rp <= rp + 4'd1;
  end
  rw_command_arbiter #(.DATA_WIDTH(32), .TURNAROUND(2), .IDLE_WRITE_DELAY(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_rd_valid(rd_valid), .i_rd_data(rd_data), .o_rd_ready(rd_ready),
    .i_wfifo_data(wdata), .i_wfifo_empty(wempty), .i_write_flush(flush), .o_wfifo_rd_en(rd_en),
    .o_cmd_valid(cmd_valid), .o_cmd_data(cmd_data), .o_cmd_is_write(cmd_is_write),
    .i_cmd_ready(cmd_ready), .o_state(state));
  rw_command_arbiter #(.DATA_WIDTH(32), .TURNAROUND(0), .IDLE_WRITE_DELAY(8)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_rd_valid(1'b0), .i_rd_data(32'd0), .o_rd_ready(z_rd_ready),
    .i_wfifo_data(z_wdata), .i_wfifo_empty(z_empty), .i_write_flush(z_flush), .o_wfifo_rd_en(z_rd_en),
    .o_cmd_valid(z_valid), .o_cmd_data(z_cmd), .o_cmd_is_write(z_wr),
    .i_cmd_ready(1'b1), .o_state(z_state));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask
  task automatic push(input logic [31:0] d);
    mem[wp] = d;
    wp = wp + 4'd1;
  endtask
  task automatic cyc;
    @(negedge clk);
    #1;
  endtask
  task automatic wait_state(input logic [1:0] s, input string tag);
    int k = 0;
    while (state != s && k < 20) begin
      cyc();
      k++;
    end
    chk(tag, 32'(state), 32'(s));
  endtask
  logic [1:0] st_e [10] = '{1, 1, 2, 2, 2, 2, 3, 3, 0, 0};
  logic       vl_e [10] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 1};
  logic [31:0] dt_e [10] = '{0, 0, 0, 32'hA0, 32'hB0, 32'hC0, 0, 0, 0, 32'h44};
  logic        wr_e [10] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 0};
  initial begin
    logic seen;
    logic [31:0] got;
    rd_valid = 1'b1;
    cyc();
    chk("rst_valid", 32'(cmd_valid), 0);
    chk("rst_state", 32'(state), 0);
    chk("rst_data", cmd_data, 0);
    chk("rst_rd_ready", 32'(rd_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    rd_valid = 1'b0;
    @(negedge clk);
    rd_valid = 1'b1;
    rd_data = 32'h11;
    #1 chk("rd_ready", 32'(rd_ready), 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rd_data = (i == 0) ? 32'h22 : 32'h33;
      if (i == 2) rd_valid = 1'b0;
      #1;
      chk("rd_valid", 32'(cmd_valid), 1);
      chk("rd_data", cmd_data, 32'h11 * (i + 1));
      chk("rd_is_write", 32'(cmd_is_write), 0);
    end
    cyc();
    chk("rd_idle", 32'(cmd_valid), 0);
    @(negedge clk);
    push(32'hA0);
    push(32'hB0);
    push(32'hC0);
    flush = 1'b1;
    rd_valid = 1'b1;
    rd_data = 32'h44;
    #1 chk("flush_rd_block", 32'(rd_ready), 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 5) flush = 1'b0;
      if (i == 9) rd_valid = 1'b0;
      #1;
      chk($sformatf("fl_state%0d", i), 32'(state), 32'(st_e[i]));
      chk($sformatf("fl_valid%0d", i), 32'(cmd_valid), 32'(vl_e[i]));
      if (vl_e[i]) begin
        chk($sformatf("fl_data%0d", i), cmd_data, dt_e[i]);
        chk($sformatf("fl_wr%0d", i), 32'(cmd_is_write), 32'(wr_e[i]));
      end
    end
    @(negedge clk);
    push(32'hD0);
    push(32'hD1);
    push(32'hD2);
    flush = 1'b1;
    #1 wait_state(2'd2, "bp_enter_write");
    chk("bp_pop_d0", 32'(rd_en), 1);
    @(negedge clk);
    cmd_ready = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) cyc();
      chk("bp_hold_data", cmd_data, 32'hD0);
      chk("bp_hold_valid", 32'(cmd_valid), 1);
      chk("bp_no_pop", 32'(rd_en), 0);
      chk("bp_no_rd", 32'(rd_ready), 0);
    end
    @(negedge clk);
    cmd_ready = 1'b1;
    #1 chk("bp_resume_pop", 32'(rd_en), 1);
    cyc();
    chk("bp_d1", cmd_data, 32'hD1);
    cyc();
    chk("bp_d2", cmd_data, 32'hD2);
    flush = 1'b0;
    wait_state(2'd0, "bp_back_read");
    @(negedge clk);
    push(32'hE0);
    push(32'hE1);
    flush = 1'b1;
    #1 wait_state(2'd2, "rst_enter_write");
    @(negedge clk);
    cmd_ready = 1'b0;
    #1 chk("rst_pre_data", cmd_data, 32'hE0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", 32'(cmd_valid), 0);
    chk("rst_mid_state", 32'(state), 0);
    chk("rst_mid_pop", 32'(rd_en), 0);
    chk("rst_mid_wr", 32'(cmd_is_write), 0);
    @(negedge clk);
    rst = 1'b0;
    flush = 1'b0;
    cmd_ready = 1'b1;
    cyc();
    chk("rst_after_state", 32'(state), 0);
    chk("rst_after_valid", 32'(cmd_valid), 0);
    @(negedge clk);
    z_empty = 1'b0;
    z_flush = 1'b1;
    z_wdata = 32'h55;
    #1 chk("t0_state_read", 32'(z_state), 0);
    cyc();
    chk("t0_state_write", 32'(z_state), 2);
    chk("t0_pop", 32'(z_rd_en), 1);
    @(negedge clk);
    z_empty = 1'b1;
    z_flush = 1'b0;
    #1;
    chk("t0_data", z_cmd, 32'h55);
    chk("t0_wr", 32'(z_wr), 1);
    cyc();
    chk("t0_back_read", 32'(z_state), 0);
    @(negedge clk);
    push(32'h66);
    seen = 1'b0;
    got = '0;
    for (int i = 0; i < 50; i++) begin
      cyc();
      if (cmd_valid && cmd_is_write && !seen) begin
        seen = 1'b1;
        got = cmd_data;
      end
    end
`ifdef RW_ARB_OPPORTUNISTIC_WRITE_EN
    chk("opp_seen", 32'(seen), 1);
    chk("opp_data", got, 32'h66);
    wait_state(2'd0, "opp_back_read");
`else
    chk("no_opp_seen", 32'(seen), 0);
    chk("no_opp_state", 32'(state), 0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
